// File: rtl/alarm_set_ctrl.sv
// Alarm setpoint editor: conditions the mode/increment buttons and edits a staged
// hour:minute that is committed to the alarm comparator atomically when set mode ends.
module alarm_set_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RST_HOUR        = 6,
  parameter int unsigned RST_MIN         = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_raw,
  input  logic       btn_inc_raw,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_load,
  output logic [1:0] set_state,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SET_HOUR = 2'b01,
    ST_SET_MIN  = 2'b10
  } state_e;

  logic [1:0] raw_s;
  logic [1:0] press_s;

  assign raw_s = {btn_inc_raw, btn_mode_raw};

  // Bit 0 is the mode button, bit 1 the increment button.
  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic          sync1_q, sync2_q, deb_q, deb_prev_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_MAX) begin
          deb_d = sync2_q;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= raw_s[b];
        sync2_q    <= sync1_q;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        cnt_q      <= cnt_d;
      end
    end

    assign press_s[b] = deb_q & ~deb_prev_q;
  end

  state_e     state_q;
  logic [4:0] alarm_h_q, edit_h_q;
  logic [5:0] alarm_m_q, edit_m_q;
  logic       load_q;

  // A mode press always wins over a simultaneous increment press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alarm_h_q <= 5'(RST_HOUR);
      alarm_m_q <= 6'(RST_MIN);
      edit_h_q  <= 5'(RST_HOUR);
      edit_m_q  <= 6'(RST_MIN);
      load_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (press_s[0]) begin
            state_q  <= ST_SET_HOUR;
            edit_h_q <= alarm_h_q;
            edit_m_q <= alarm_m_q;
          end
        end
        ST_SET_HOUR: begin
          if (press_s[0]) begin
            state_q <= ST_SET_MIN;
          end else if (press_s[1]) begin
            edit_h_q <= (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
          end
        end
        ST_SET_MIN: begin
          if (press_s[0]) begin
            state_q   <= ST_IDLE;
            alarm_h_q <= edit_h_q;
            alarm_m_q <= edit_m_q;
            load_q    <= 1'b1;
          end else if (press_s[1]) begin
            edit_m_q <= (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alarm_hours   = alarm_h_q;
  assign alarm_minutes = alarm_m_q;
  assign alarm_load    = load_q;
  assign set_state     = state_q;
  assign edit_hours    = edit_h_q;
  assign edit_minutes  = edit_m_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Self-checking bench for alarm_set_ctrl: directed scenarios with literal expectations
// followed by random button activity, all compared every cycle against a behavioural model.
module tb_alarm_set_ctrl;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode_raw = 1'b0;
  logic       btn_inc_raw = 1'b0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_load;
  logic [1:0] set_state;
  logic [4:0] edit_hours;
  logic [5:0] edit_minutes;

  int n_cmp = 0;
  int n_bad = 0;

  alarm_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .RST_HOUR(6), .RST_MIN(0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode_raw(btn_mode_raw), .btn_inc_raw(btn_inc_raw),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_load(alarm_load),
    .set_state(set_state), .edit_hours(edit_hours), .edit_minutes(edit_minutes)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endfunction

  // Behavioural model: raw samples reach the debouncer two edges late; a level is
  // accepted after DEB consecutive differing samples; a rising level acts one edge later.
  int q_raw[2][$];
  int lvl[2], run[2], pend[2];
  int m_st, m_eh, m_em, m_ah, m_am, m_ld;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      q_raw[b] = {0, 0};
      lvl[b] = 0; run[b] = 0; pend[b] = 0;
    end
    m_st = 0; m_eh = 6; m_em = 0; m_ah = 6; m_am = 0; m_ld = 0;
  endfunction

  function automatic void model_step(input int raw_m, input int raw_i);
    int s[2];
    int rose[2];
    s[0] = q_raw[0].pop_front(); q_raw[0].push_back(raw_m);
    s[1] = q_raw[1].pop_front(); q_raw[1].push_back(raw_i);
    for (int b = 0; b < 2; b++) begin
      rose[b] = 0;
      if (s[b] != lvl[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          lvl[b] = s[b];
          run[b] = 0;
          rose[b] = s[b];
        end
      end else begin
        run[b] = 0;
      end
    end
    m_ld = 0;
    if (pend[0] != 0) begin
      if (m_st == 0) begin m_eh = m_ah; m_em = m_am; m_st = 1; end
      else if (m_st == 1) m_st = 2;
      else begin m_ah = m_eh; m_am = m_em; m_ld = 1; m_st = 0; end
    end else if (pend[1] != 0) begin
      if (m_st == 1) m_eh = (m_eh + 1) % 24;
      else if (m_st == 2) m_em = (m_em + 1) % 60;
    end
    pend[0] = rose[0];
    pend[1] = rose[1];
  endfunction

  initial model_reset();

  always @(negedge rst_n) model_reset();

  // Single compare process: advance the model each edge and check all outputs 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(int'(btn_mode_raw), int'(btn_inc_raw));
    #1;
    chk("alarm_hours",   int'(alarm_hours),   m_ah);
    chk("alarm_minutes", int'(alarm_minutes), m_am);
    chk("alarm_load",    int'(alarm_load),    m_ld);
    chk("set_state",     int'(set_state),     m_st);
    chk("edit_hours",    int'(edit_hours),    m_eh);
    chk("edit_minutes",  int'(edit_minutes),  m_em);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press_mode();
    btn_mode_raw = 1'b1; tick(8);
    btn_mode_raw = 1'b0; tick(8);
  endtask

  task automatic press_inc();
    btn_inc_raw = 1'b1; tick(8);
    btn_inc_raw = 1'b0; tick(8);
  endtask

  initial begin
    int load_seen;
    tick(3);
    rst_n = 1'b1;

    // Idle after reset: setpoint untouched, no load pulses.
    load_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (alarm_load) load_seen++;
    end
    chk("t1_load_quiet", load_seen, 0);
    chk("t1_alarm_h", int'(alarm_hours), 6);
    chk("t1_alarm_m", int'(alarm_minutes), 0);
    chk("t1_edit_h", int'(edit_hours), 6);
    chk("t1_state", int'(set_state), 0);

    // Short glitch then a held press in SET_HOUR.
    press_mode();
    chk("t2_state", int'(set_state), 1);
    btn_inc_raw = 1'b1; tick(3);
    btn_inc_raw = 1'b0; tick(10);
    chk("t2_glitch", int'(edit_hours), 6);
    btn_inc_raw = 1'b1; tick(6);
    chk("t2_before_e6", int'(edit_hours), 6);
    tick(1);
    chk("t2_at_e6", int'(edit_hours), 7);
    tick(3);
    btn_inc_raw = 1'b0; tick(10);
    chk("t2_no_repeat", int'(edit_hours), 7);

    // Hour wrap 23 -> 0, setpoint unchanged while editing.
    for (int i = 0; i < 16; i++) press_inc();
    chk("t3_h23", int'(edit_hours), 23);
    press_inc();
    chk("t3_h0", int'(edit_hours), 0);
    chk("t3_alarm_h", int'(alarm_hours), 6);

    // Minute wrap 59 -> 0 without hour carry, then commit.
    press_mode();
    chk("t4_state", int'(set_state), 2);
    for (int i = 0; i < 59; i++) press_inc();
    chk("t4_m59", int'(edit_minutes), 59);
    press_inc();
    chk("t4_m0", int'(edit_minutes), 0);
    chk("t4_h_nocarry", int'(edit_hours), 0);
    btn_mode_raw = 1'b1; tick(6);
    chk("t4_load_before", int'(alarm_load), 0);
    tick(1);
    chk("t4_load", int'(alarm_load), 1);
    chk("t4_commit_m", int'(alarm_minutes), 0);
    chk("t4_commit_h", int'(alarm_hours), 0);
    chk("t4_idle", int'(set_state), 0);
    tick(1);
    chk("t4_load_once", int'(alarm_load), 0);
    btn_mode_raw = 1'b0; tick(10);

    // Simultaneous mode and inc in SET_MIN: commit the unincremented value.
    press_mode();
    press_mode();
    for (int i = 0; i < 10; i++) press_inc();
    chk("t5_m10", int'(edit_minutes), 10);
    btn_mode_raw = 1'b1; btn_inc_raw = 1'b1; tick(7);
    chk("t5_state", int'(set_state), 0);
    chk("t5_alarm_m", int'(alarm_minutes), 10);
    chk("t5_load", int'(alarm_load), 1);
    tick(1);
    chk("t5_load_once", int'(alarm_load), 0);
    btn_mode_raw = 1'b0; btn_inc_raw = 1'b0; tick(10);

    // Asynchronous reset in the middle of an edit.
    press_mode();
    for (int i = 0; i < 15; i++) press_inc();
    chk("t6_h15", int'(edit_hours), 15);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_alarm_h", int'(alarm_hours), 6);
    chk("t6_rst_alarm_m", int'(alarm_minutes), 0);
    chk("t6_rst_edit_h", int'(edit_hours), 6);
    chk("t6_rst_state", int'(set_state), 0);
    chk("t6_rst_load", int'(alarm_load), 0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    press_mode();
    chk("t6_after_state", int'(set_state), 1);
    chk("t6_after_edit_h", int'(edit_hours), 6);

    // Random button activity with varied hold lengths, including bounces.
    for (int seg = 0; seg < 400; seg++) begin
      btn_mode_raw = 1'($urandom_range(0, 1));
      btn_inc_raw  = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 14));
    end
    btn_mode_raw = 1'b0; btn_inc_raw = 1'b0;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
